// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module  : vga_timing_gen_if
// Brief   : Coordinate / colour exchange between the timing generator and console
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  logic [10:0] monitor_h_coord;
  logic [9:0]  monitor_v_coord;
  logic        monitor_enable;
  logic [3:0]  monitor_r;
  logic [3:0]  monitor_g;
  logic [3:0]  monitor_b;

  modport master (
    output monitor_h_coord, monitor_v_coord, monitor_enable,
    input  monitor_r, monitor_g, monitor_b
  );

  modport slave (
    input  monitor_h_coord, monitor_v_coord, monitor_enable,
    output monitor_r, monitor_g, monitor_b
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : 800x600@72 VGA raster timing with registered, blanked pin stage.
//           Optional colour bars when VGA_TIMING_TEST_PATTERN_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter int SYNC_POS = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vga_timing_gen_if.master  mon_if,
  input  wire logic         test_pattern_i,
  output logic [3:0]        vga_r_o,
  output logic [3:0]        vga_g_o,
  output logic [3:0]        vga_b_o,
  output logic              vga_hsync_o,
  output logic              vga_vsync_o,
  output logic              pixel_tick_o,
  output logic              frame_start_o
);

  localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_last     = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] c_hs_first   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] c_hs_last    = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0]  c_v_last     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  c_vs_first   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  c_vs_last    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic        c_sync_on    = (SYNC_POS != 0);

  logic        w_tick;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic        w_enable;
  logic        w_hs_in;
  logic        w_vs_in;
  logic        w_wrap;
  logic [11:0] w_src_rgb;

  generate
    if (CLK_DIV <= 1) begin : g_no_div
      assign w_tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] c_div_last = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_q, div_d;

      always_comb begin
        div_d = (div_q == c_div_last) ? '0 : div_q + DW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
      end

      assign w_tick = (div_q == c_div_last);
    end
  endgenerate

  assign w_enable = (h_q < c_h_active) && (v_q < c_v_active);
  assign w_hs_in  = (h_q >= c_hs_first) && (h_q <= c_hs_last);
  assign w_vs_in  = (v_q >= c_vs_first) && (v_q <= c_vs_last);
  assign w_wrap   = w_tick && (h_q == c_h_last) && (v_q == c_v_last);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [2:0]  w_bar_idx;
  logic [11:0] w_bar_rgb;

  // Bars are 100 px wide regardless of H_ACTIVE; a compare chain avoids a divider.
  always_comb begin
    if      (h_q < 11'd100) w_bar_idx = 3'd0;
    else if (h_q < 11'd200) w_bar_idx = 3'd1;
    else if (h_q < 11'd300) w_bar_idx = 3'd2;
    else if (h_q < 11'd400) w_bar_idx = 3'd3;
    else if (h_q < 11'd500) w_bar_idx = 3'd4;
    else if (h_q < 11'd600) w_bar_idx = 3'd5;
    else if (h_q < 11'd700) w_bar_idx = 3'd6;
    else                    w_bar_idx = 3'd7;
  end

  always_comb begin
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 12'hFFF;
      3'd1:    w_bar_rgb = 12'hFF0;
      3'd2:    w_bar_rgb = 12'h0FF;
      3'd3:    w_bar_rgb = 12'h0F0;
      3'd4:    w_bar_rgb = 12'hF0F;
      3'd5:    w_bar_rgb = 12'hF00;
      3'd6:    w_bar_rgb = 12'h00F;
      default: w_bar_rgb = 12'h000;
    endcase
  end

  assign w_src_rgb = test_pattern_i ? w_bar_rgb
                                    : {mon_if.monitor_r, mon_if.monitor_g, mon_if.monitor_b};
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern_i;
  assign w_src_rgb = {mon_if.monitor_r, mon_if.monitor_g, mon_if.monitor_b};
`endif

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (w_tick) begin
      if (h_q == c_h_last) begin
        h_d = '0;
        v_d = (v_q == c_v_last) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  // Console reply is sampled on the same tick edge that advances the counters,
  // so colour and sync both lag the coordinates by exactly one pixel.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = w_wrap;
    if (w_tick) begin
      rgb_d = w_enable ? w_src_rgb : 12'h000;
      hs_d  = ~(c_sync_on ^ w_hs_in);
      vs_d  = ~(c_sync_on ^ w_vs_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      hs_q  <= ~c_sync_on;
      vs_q  <= ~c_sync_on;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign mon_if.monitor_h_coord = h_q;
  assign mon_if.monitor_v_coord = v_q;
  assign mon_if.monitor_enable  = w_enable;
  assign vga_r_o       = rgb_q[11:8];
  assign vga_g_o       = rgb_q[7:4];
  assign vga_b_o       = rgb_q[3:0];
  assign vga_hsync_o   = hs_q;
  assign vga_vsync_o   = vs_q;
  assign pixel_tick_o  = w_tick;
  assign frame_start_o = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Directed checks of full-size, reduced-size and divided-clock raster
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tp  = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_full ();
  vga_timing_gen_if if_small ();
  vga_timing_gen_if if_div2 ();

  logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b, d_r, d_g, d_b;
  logic f_hs, f_vs, f_tk, f_fs, s_hs, s_vs, s_tk, s_fs, d_hs, d_vs, d_tk, d_fs;

  vga_timing_gen u_full (
    .clk(clk), .rst(rst), .mon_if(if_full.master), .test_pattern_i(tp),
    .vga_r_o(f_r), .vga_g_o(f_g), .vga_b_o(f_b),
    .vga_hsync_o(f_hs), .vga_vsync_o(f_vs),
    .pixel_tick_o(f_tk), .frame_start_o(f_fs)
  );

  // 24 x 10 raster: sync on h 18..20, v 7..8
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clk(clk), .rst(rst), .mon_if(if_small.master), .test_pattern_i(1'b0),
    .vga_r_o(s_r), .vga_g_o(s_g), .vga_b_o(s_b),
    .vga_hsync_o(s_hs), .vga_vsync_o(s_vs),
    .pixel_tick_o(s_tk), .frame_start_o(s_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_div2 (
    .clk(clk), .rst(rst), .mon_if(if_div2.master), .test_pattern_i(1'b0),
    .vga_r_o(d_r), .vga_g_o(d_g), .vga_b_o(d_b),
    .vga_hsync_o(d_hs), .vga_vsync_o(d_vs),
    .pixel_tick_o(d_tk), .frame_start_o(d_fs)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_full_h",   32'(if_full.monitor_h_coord), 0);
    check("rst_full_v",   32'(if_full.monitor_v_coord), 0);
    check("rst_full_en",  32'(if_full.monitor_enable), 1);
    check("rst_full_rgb", 32'({f_r, f_g, f_b}), 0);
    check("rst_full_hs",  32'(f_hs), 0);
    check("rst_full_vs",  32'(f_vs), 0);
    check("rst_full_tk",  32'(f_tk), 1);
    check("rst_full_fs",  32'(f_fs), 0);
    check("rst_small_h",  32'(if_small.monitor_h_coord), 0);
    check("rst_small_v",  32'(if_small.monitor_v_coord), 0);
    check("rst_small_rgb", 32'({s_r, s_g, s_b}), 0);
    check("rst_small_fs", 32'(s_fs), 0);
    check("rst_div2_tk",  32'(d_tk), 0);
    check("rst_div2_h",   32'(if_div2.monitor_h_coord), 0);
    check("rst_div2_hs",  32'(d_hs), 0);
  endtask

  initial begin
    int p, ps, pd, fs1, fs2;

    if_full.monitor_r  = 4'hF; if_full.monitor_g  = 4'h0; if_full.monitor_b  = 4'hA;
    if_small.monitor_r = 4'h5; if_small.monitor_g = 4'h6; if_small.monitor_b = 4'h7;
    if_div2.monitor_r  = 4'h1; if_div2.monitor_g  = 4'h2; if_div2.monitor_b  = 4'h3;

    repeat (3) tick();
    check_reset_state();
    rst = 1'b0;

    // After edge k the counters hold position k and the pins show position k-1.
    for (int k = 1; k <= 1440; k++) begin
      tick();
      p  = (k - 1) % 1040;
      ps = (k - 1) % 240;
      check("full_h",   32'(if_full.monitor_h_coord), 32'(k % 1040));
      check("full_v",   32'(if_full.monitor_v_coord), 32'(k / 1040));
      check("full_en",  32'(if_full.monitor_enable), ((k % 1040) < 800) ? 1 : 0);
      check("full_rgb", 32'({f_r, f_g, f_b}), (p < 800) ? 32'hF0A : 0);
      check("full_hs",  32'(f_hs), (p >= 856 && p <= 975) ? 1 : 0);
      check("full_tk",  32'(f_tk), 1);
      check("small_h",  32'(if_small.monitor_h_coord), 32'(k % 24));
      check("small_v",  32'(if_small.monitor_v_coord), 32'((k / 24) % 10));
      check("small_rgb", 32'({s_r, s_g, s_b}), ((ps % 24) < 16 && (ps / 24) < 6) ? 32'h567 : 0);
      check("small_hs", 32'(s_hs), ((ps % 24) >= 18 && (ps % 24) <= 20) ? 1 : 0);
      check("small_vs", 32'(s_vs), ((ps / 24) >= 7 && (ps / 24) <= 8) ? 1 : 0);
      check("small_fs", 32'(s_fs), (k % 240 == 0) ? 1 : 0);
      check("div2_tk",  32'(d_tk), 32'(k % 2));
      check("div2_h",   32'(if_div2.monitor_h_coord), 32'((k / 2) % 24));
      pd = (k / 2 - 1) % 24;
      check("div2_hs",  32'(d_hs), (k >= 2 && pd >= 18 && pd <= 20) ? 1 : 0);
    end

    // Full raster now sits at h=400 on line 1 with live colour on the pins.
    rst = 1'b1;
    tick();
    check_reset_state();

    tp  = 1'b1;
    rst = 1'b0;
    fs1 = -1;
    fs2 = -1;
    for (int e = 1; e <= 760; e++) begin
      tick();
      if (s_fs) begin
        if (fs1 < 0) begin
          fs1 = e;
          check("fs_small_h0", 32'(if_small.monitor_h_coord), 0);
          check("fs_small_v0", 32'(if_small.monitor_v_coord), 0);
        end else if (fs2 < 0) begin
          fs2 = e;
        end
      end
      if (e == 151) check("tp_h150", 32'({f_r, f_g, f_b}), TP_EN ? 32'hFF0 : 32'hF0A);
      if (e == 201) check("tp_h200", 32'({f_r, f_g, f_b}), TP_EN ? 32'h0FF : 32'hF0A);
      if (e == 751) check("tp_h750", 32'({f_r, f_g, f_b}), TP_EN ? 32'h000 : 32'hF0A);
      if (e == 755) tp = 1'b0;
      if (e == 760) check("tp_off",  32'({f_r, f_g, f_b}), 32'hF0A);
    end
    check("fs_first_after_rst", 32'(fs1), 240);
    check("fs_period",          32'(fs2 - fs1), 240);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
